// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order ROB head retirement: regfile write, store release, mispredict flush.
// Optional ROB_COMMIT_PERF_EN adds saturating mispredict/stall performance counters.
module rob_commit #(
    parameter int FLUSH_HOLD = 1,
    parameter int ROB_IDX_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 head_valid_i,
    input  logic                 head_done_i,
    input  logic [ROB_IDX_W-1:0] head_idx_i,
    input  logic [31:0]          head_pc_i,
    input  logic [4:0]           head_rd_addr_i,
    input  logic [31:0]          head_rd_data_i,
    input  logic                 head_regf_we_i,
    input  logic                 head_is_store_i,
    input  logic                 head_is_br_i,
    input  logic                 head_br_en_i,
    input  logic                 head_pred_i,
    input  logic [31:0]          head_pc_new_i,
    input  logic                 store_ack_i,
    output logic                 dequeue_o,
    output logic                 regf_we_o,
    output logic [4:0]           regf_rd_o,
    output logic [31:0]          regf_data_o,
    output logic [ROB_IDX_W-1:0] regf_rob_idx_o,
    output logic                 store_commit_o,
    output logic                 flush_o,
    output logic [31:0]          redirect_pc_o,
    output logic [63:0]          retired_o
`ifdef ROB_COMMIT_PERF_EN
    ,
    output logic [31:0]          perf_mispred_o,
    output logic [31:0]          perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  hold_q, hold_d;
    logic [63:0] retired_q, retired_d;
    logic        retire;

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        retire         = 1'b0;
        dequeue_o      = 1'b0;
        regf_we_o      = 1'b0;
        regf_rd_o      = 5'd0;
        regf_data_o    = 32'd0;
        regf_rob_idx_o = '0;
        store_commit_o = 1'b0;
        flush_o        = 1'b0;
        redirect_pc_o  = 32'd0;

        case (state_q)
            RUN: begin
                if (head_valid_i && head_done_i) begin
                    if (head_is_store_i) begin
                        store_commit_o = 1'b1;
                        state_d        = STORE_WAIT;
                    end else if (head_is_br_i && (head_br_en_i != head_pred_i)) begin
                        // ROB advances its own head on flush, so no dequeue here
                        flush_o       = 1'b1;
                        retire        = 1'b1;
                        redirect_pc_o = head_br_en_i ? head_pc_new_i : head_pc_i + 32'd4;
                        state_d       = FLUSH;
                        hold_d        = 4'(FLUSH_HOLD);
                    end else begin
                        dequeue_o = 1'b1;
                        retire    = 1'b1;
                    end
                end
            end
            STORE_WAIT: begin
                if (store_ack_i) begin
                    dequeue_o = 1'b1;
                    retire    = 1'b1;
                    state_d   = RUN;
                end
            end
            FLUSH: begin
                hold_d = hold_q - 4'd1;
                if (hold_q <= 4'd1) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (retire) begin
            regf_we_o      = head_regf_we_i && (head_rd_addr_i != 5'd0);
            regf_rd_o      = head_rd_addr_i;
            regf_data_o    = head_rd_data_i;
            regf_rob_idx_o = head_idx_i;
        end

        retired_d = retired_q + 64'(retire);
        retired_o = retired_q;

        if (rst) begin
            dequeue_o      = 1'b0;
            regf_we_o      = 1'b0;
            regf_rd_o      = 5'd0;
            regf_data_o    = 32'd0;
            regf_rob_idx_o = '0;
            store_commit_o = 1'b0;
            flush_o        = 1'b0;
            redirect_pc_o  = 32'd0;
            retired_o      = 64'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            hold_q    <= 4'd0;
            retired_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            retired_q <= retired_d;
        end
    end

`ifdef ROB_COMMIT_PERF_EN
    logic [31:0] mispred_q, mispred_d;
    logic [31:0] stall_q, stall_d;
    logic        stall_ev;

    always_comb begin
        stall_ev  = ((state_q == RUN) && head_valid_i && !head_done_i) || (state_q == STORE_WAIT);
        mispred_d = (flush_o && (mispred_q != 32'hFFFF_FFFF)) ? mispred_q + 32'd1 : mispred_q;
        stall_d   = (stall_ev && (stall_q != 32'hFFFF_FFFF)) ? stall_q + 32'd1 : stall_q;
        perf_mispred_o = mispred_q;
        perf_stall_o   = stall_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mispred_q <= 32'd0;
            stall_q   <= 32'd0;
        end else begin
            mispred_q <= mispred_d;
            stall_q   <= stall_d;
        end
    end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed table-driven bench for rob_commit (FLUSH_HOLD=1).
module tb_rob_commit;

    logic        clk = 1'b0;
    logic        rst;
    logic        head_valid_i, head_done_i;
    logic [4:0]  head_idx_i;
    logic [31:0] head_pc_i;
    logic [4:0]  head_rd_addr_i;
    logic [31:0] head_rd_data_i;
    logic        head_regf_we_i, head_is_store_i, head_is_br_i, head_br_en_i, head_pred_i;
    logic [31:0] head_pc_new_i;
    logic        store_ack_i;
    logic        dequeue_o, regf_we_o, store_commit_o, flush_o;
    logic [4:0]  regf_rd_o, regf_rob_idx_o;
    logic [31:0] regf_data_o, redirect_pc_o;
    logic [63:0] retired_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rob_commit #(.FLUSH_HOLD(1), .ROB_IDX_W(5)) dut (
        .clk(clk), .rst(rst),
        .head_valid_i(head_valid_i), .head_done_i(head_done_i), .head_idx_i(head_idx_i),
        .head_pc_i(head_pc_i), .head_rd_addr_i(head_rd_addr_i), .head_rd_data_i(head_rd_data_i),
        .head_regf_we_i(head_regf_we_i), .head_is_store_i(head_is_store_i),
        .head_is_br_i(head_is_br_i), .head_br_en_i(head_br_en_i), .head_pred_i(head_pred_i),
        .head_pc_new_i(head_pc_new_i), .store_ack_i(store_ack_i),
        .dequeue_o(dequeue_o), .regf_we_o(regf_we_o), .regf_rd_o(regf_rd_o),
        .regf_data_o(regf_data_o), .regf_rob_idx_o(regf_rob_idx_o),
        .store_commit_o(store_commit_o), .flush_o(flush_o), .redirect_pc_o(redirect_pc_o),
        .retired_o(retired_o)
    );

    typedef struct {
        logic        v, d;
        logic [4:0]  idx;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we, st, br, bren, pred;
        logic [31:0] pcn;
        logic        ack;
        logic        e_deq, e_we, e_sc, e_fl;
        logic [31:0] e_redir;
        logic [63:0] e_ret;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic v, logic d, logic [4:0] idx, logic [31:0] pc, logic [4:0] rd,
                                logic [31:0] data, logic we, logic st, logic br, logic bren,
                                logic pred, logic [31:0] pcn, logic ack, logic e_deq, logic e_we,
                                logic e_sc, logic e_fl, logic [31:0] e_redir, logic [63:0] e_ret);
        vec_t r;
        r.v = v; r.d = d; r.idx = idx; r.pc = pc; r.rd = rd; r.data = data; r.we = we;
        r.st = st; r.br = br; r.bren = bren; r.pred = pred; r.pcn = pcn; r.ack = ack;
        r.e_deq = e_deq; r.e_we = e_we; r.e_sc = e_sc; r.e_fl = e_fl;
        r.e_redir = e_redir; r.e_ret = e_ret;
        return r;
    endfunction

    task automatic chk(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h want %0h", name, n, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        head_valid_i = t.v; head_done_i = t.d; head_idx_i = t.idx; head_pc_i = t.pc;
        head_rd_addr_i = t.rd; head_rd_data_i = t.data; head_regf_we_i = t.we;
        head_is_store_i = t.st; head_is_br_i = t.br; head_br_en_i = t.bren;
        head_pred_i = t.pred; head_pc_new_i = t.pcn; store_ack_i = t.ack;
    endtask

    // Drive one cycle, sample on the falling edge, then advance past the rising edge.
    task automatic run_vec(input vec_t t, input int n);
        logic ret_cyc;
        drive(t);
        @(negedge clk);
        ret_cyc = t.e_deq | t.e_fl;
        chk("dequeue", n, 64'(dequeue_o), 64'(t.e_deq));
        chk("regf_we", n, 64'(regf_we_o), 64'(t.e_we));
        chk("store_commit", n, 64'(store_commit_o), 64'(t.e_sc));
        chk("flush", n, 64'(flush_o), 64'(t.e_fl));
        chk("redirect", n, 64'(redirect_pc_o), 64'(t.e_redir));
        chk("retired", n, retired_o, t.e_ret);
        chk("regf_rd", n, 64'(regf_rd_o), ret_cyc ? 64'(t.rd) : 64'd0);
        chk("regf_data", n, 64'(regf_data_o), ret_cyc ? 64'(t.data) : 64'd0);
        chk("rob_idx", n, 64'(regf_rob_idx_o), ret_cyc ? 64'(t.idx) : 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t alu, idle;
        alu  = mk(1,1,5'd3,32'h100,5'd5,32'hDEADBEEF,1,0,0,0,0,0,0, 1,1,0,0,0,0);
        idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);

        //        v d idx  pc            rd    data          we st br en pr pcn           ack deq we sc fl redir         ret
        tv.push_back(mk(1,1,5'd3,32'h100,     5'd5,32'hDEADBEEF,1,0,0,0,0,32'h0,       0,  1,1,0,0,32'h0,        64'd0));
        tv.push_back(mk(1,1,5'd4,32'h104,     5'd0,32'h1234,    1,0,0,0,0,32'h0,       0,  1,0,0,0,32'h0,        64'd1));
        tv.push_back(mk(1,0,5'd5,32'h108,     5'd6,32'h55,      1,0,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd2));
        tv.push_back(mk(0,1,5'd5,32'h108,     5'd6,32'h55,      1,0,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd2));
        tv.push_back(mk(1,1,5'd5,32'h3000,    5'd1,32'h3004,    1,0,1,1,1,32'h4000,    0,  1,1,0,0,32'h0,        64'd2));
        tv.push_back(mk(1,1,5'd6,32'h1000,    5'd0,32'h0,       0,0,1,0,1,32'h5000,    0,  0,0,0,1,32'h1004,     64'd3));
        tv.push_back(mk(1,1,5'd7,32'h1004,    5'd2,32'h7,       1,0,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd4));
        tv.push_back(mk(1,1,5'd7,32'h1004,    5'd2,32'h7,       1,0,0,0,0,32'h0,       0,  1,1,0,0,32'h0,        64'd4));
        tv.push_back(mk(1,1,5'd8,32'h1800,    5'd3,32'h1804,    1,0,1,1,0,32'h2000,    0,  0,1,0,1,32'h2000,     64'd5));
        tv.push_back(mk(1,1,5'd9,32'h2000,    5'd0,32'h0,       0,1,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd6));
        tv.push_back(mk(1,1,5'd9,32'h2000,    5'd0,32'h0,       0,1,0,0,0,32'h0,       1,  0,0,1,0,32'h0,        64'd6));
        tv.push_back(mk(1,1,5'd9,32'h2000,    5'd0,32'h0,       0,1,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd6));
        tv.push_back(mk(1,1,5'd9,32'h2000,    5'd0,32'h0,       0,1,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd6));
        tv.push_back(mk(1,1,5'd9,32'h2000,    5'd0,32'h0,       0,1,0,0,0,32'h0,       1,  1,0,0,0,32'h0,        64'd6));
        tv.push_back(mk(0,0,5'd0,32'h0,       5'd0,32'h0,       0,0,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd7));
        tv.push_back(mk(1,1,5'd10,32'hFFFFFFFC,5'd0,32'h0,      0,0,1,0,1,32'h9000,    0,  0,0,0,1,32'h0,        64'd7));
        tv.push_back(mk(1,1,5'd11,32'h0,      5'd4,32'h44,      1,0,0,0,0,32'h0,       0,  0,0,0,0,32'h0,        64'd8));
        tv.push_back(mk(1,1,5'd11,32'h0,      5'd4,32'h44,      1,0,0,0,0,32'h0,       0,  1,1,0,0,32'h0,        64'd8));

        // Reset held two cycles with a valid/done head: everything stays 0.
        drive(alu);
        rst = 1'b1;
        #1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("rst_dequeue", c, 64'(dequeue_o), 64'd0);
            chk("rst_regf_we", c, 64'(regf_we_o), 64'd0);
            chk("rst_flush", c, 64'(flush_o), 64'd0);
            chk("rst_retired", c, retired_o, 64'd0);
            chk("rst_data", c, 64'(regf_data_o), 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Second rst cycle above already let one edge pass with rst=1; table starts from reset state.
        for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

        // 32 back-to-back retirements from a fresh reset.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            alu.idx = 5'(i);
            alu.e_ret = 64'(i);
            run_vec(alu, 100 + i);
        end
        drive(idle);
        @(negedge clk);
        chk("retired_32", 132, retired_o, 64'd32);
        @(posedge clk);
        #1;

        // Reset while waiting for a store ack abandons the store and resumes in RUN.
        run_vec(mk(1,1,5'd1,32'h0,5'd0,32'h0,0,1,0,0,0,32'h0,0, 0,0,1,0,32'h0,64'd32), 200);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        alu.idx = 5'd3;
        alu.e_ret = 64'd0;
        run_vec(alu, 201);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
